// File: rtl/spi_pkg.sv
// Shared types for the SPI slave datapath.
// Command codes, transmit FSM states, idle fill byte.
package spi_pkg;

  typedef enum logic [7:0] {
    SET_ST = 8'h2a,
    REG_RD = 8'h3a
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_CMD = 2'd1,
    SHIFT_RD  = 2'd2
  } state_t;

  localparam logic [7:0] IDLE_BYTE_DEF = 8'h00;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus history flop.
// Emits one-cycle rise/fall strobes in clk_i.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic hist_q, hist_d;

  // next values of the synchroniser chain
  always_comb begin
    s1_d   = d_i;
    s2_d   = s1_q;
    hist_d = s2_q;
  end

  // synchroniser and history registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      hist_q <= RST_VAL;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      hist_q <= hist_d;
    end
  end

  assign rise_o = s2_q & ~hist_q;
  assign fall_o = ~s2_q & hist_q;

endmodule

// File: rtl/reg_readback_tx.sv
// SPI mode-0 MISO path for register readback.
// Arms on REG_RD, returns reg bytes per data byte.
module reg_readback_tx
  import spi_pkg::*;
#(
  parameter int         REG_BYTES = 8,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   spi_sclk_i,
  input  logic                   spi_cs_n_i,
  input  logic                   dc_i,
  input  logic                   spi_byte_vld_i,
  input  logic [7:0]             spi_byte_data_i,
  input  logic [2:0]             reg_rd_addr_i,
  input  logic [8*REG_BYTES-1:0] reg_data_i,
  output logic                   spi_miso_o,
  output logic                   spi_miso_oe_o,
  output logic                   tx_byte_done_o
);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;

  sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d_i    (spi_sclk_i),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d_i    (spi_cs_n_i),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  logic [7:0] rd_bytes [8];

  for (genvar k = 0; k < 8; k++) begin : g_rd
    if (k < REG_BYTES) begin : g_v
      assign rd_bytes[k] = reg_data_i[8*k +: 8];
    end else begin : g_i
      assign rd_bytes[k] = IDLE_BYTE;
    end
  end

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       miso_q, miso_d;
  logic       oe_q, oe_d;
  logic       done_q, done_d;
  logic       ld_dly_q, ld_dly_d;
  logic       done_pend_q, done_pend_d;

  // next-state, shifting, load and done pulse
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    oe_d        = oe_q;
    done_d      = 1'b0;
    ld_dly_d    = spi_byte_vld_i;
    done_pend_d = spi_byte_vld_i & dc_i &
                  (state_q == SHIFT_RD);
    if (cs_rise) begin
      state_d   = IDLE;
      shift_d   = 8'h00;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
    end else if (cs_fall) begin
      state_d   = SHIFT_CMD;
      shift_d   = IDLE_BYTE;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b1;
    end else if (state_q != IDLE) begin
      if (sclk_rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (sclk_fall && bit_cnt_q != 3'd0) begin
        shift_d = {shift_q[6:0], 1'b0};
      end
      if (ld_dly_q) begin
        shift_d = (state_q == SHIFT_RD) ?
                  rd_bytes[reg_rd_addr_i] : IDLE_BYTE;
        done_d  = done_pend_q;
      end
      if (spi_byte_vld_i && !dc_i) begin
        state_d = (spi_byte_data_i == REG_RD) ?
                  SHIFT_RD : SHIFT_CMD;
      end
    end
    miso_d = shift_d[7];
  end

  // state and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
      ld_dly_q    <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      done_q      <= done_d;
      ld_dly_q    <= ld_dly_d;
      done_pend_q <= done_pend_d;
    end
  end

  assign spi_miso_o     = miso_q;
  assign spi_miso_oe_o  = oe_q;
  assign tx_byte_done_o = done_q;

endmodule

// File: tb/tb_reg_readback_tx.sv
// Randomised bench for reg_readback_tx.
// SPI master, receiver/decoder stub, byte-level model.
module tb_reg_readback_tx;

  localparam int RB = 4;
  localparam int H  = 8;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          spi_sclk_i;
  logic          spi_cs_n_i;
  logic          dc_i;
  logic          spi_byte_vld_i;
  logic [7:0]    spi_byte_data_i;
  logic [2:0]    reg_rd_addr_i;
  logic [8*RB-1:0] reg_data_i;
  logic          spi_miso_o;
  logic          spi_miso_oe_o;
  logic          tx_byte_done_o;

  always #5 clk = ~clk;

  reg_readback_tx #(.REG_BYTES(RB)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .spi_sclk_i     (spi_sclk_i),
    .spi_cs_n_i     (spi_cs_n_i),
    .dc_i           (dc_i),
    .spi_byte_vld_i (spi_byte_vld_i),
    .spi_byte_data_i(spi_byte_data_i),
    .reg_rd_addr_i  (reg_rd_addr_i),
    .reg_data_i     (reg_data_i),
    .spi_miso_o     (spi_miso_o),
    .spi_miso_oe_o  (spi_miso_oe_o),
    .tx_byte_done_o (tx_byte_done_o)
  );

  int vecs = 0;
  int errs = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (tx_byte_done_o === 1'b1) done_cnt <= done_cnt + 1;
  end

  logic [7:0] regs [RB];
  logic       m_armed;
  int         m_idx;
  logic       d_armed;
  logic [2:0] d_addr;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_regs();
    for (int k = 0; k < RB; k++) reg_data_i[8*k +: 8] = regs[k];
  endtask

  function automatic logic [7:0] exp_byte();
    int idx;
    if (!m_armed) return 8'h00;
    idx = m_idx % 8;
    if (idx < RB) return regs[idx];
    return 8'h00;
  endfunction

  task automatic rx_pulse(input logic [7:0] b, input logic dc);
    spi_byte_vld_i  = 1'b1;
    spi_byte_data_i = b;
    dc_i            = dc;
    tick(1);
    spi_byte_vld_i = 1'b0;
    if (!dc) begin
      d_armed = (b == 8'h3a);
      d_addr  = 3'd0;
    end else if (d_armed) begin
      d_addr = d_addr + 3'd1;
    end
    reg_rd_addr_i = d_addr;
  endtask

  task automatic shift_bits(input logic [7:0] b, input logic dc,
                            input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      tick(H);
      got = {got[6:0], spi_miso_o};
      spi_sclk_i = 1'b1;
      if (i == 7) begin
        tick(4);
        rx_pulse(b, dc);
        tick(H - 5);
      end else begin
        tick(H);
      end
      spi_sclk_i = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic dc);
    logic [7:0] exp, got;
    int c0;
    exp = exp_byte();
    c0  = done_cnt;
    shift_bits(b, dc, 8, got);
    chk("miso_byte", {24'h0, got}, {24'h0, exp});
    chk("done_pulses", 32'(done_cnt - c0),
        32'((m_armed && dc) ? 1 : 0));
    chk("oe_in_frame", {31'h0, spi_miso_oe_o}, 32'h1);
    if (!dc) begin
      m_armed = (b == 8'h3a);
      m_idx   = 0;
    end else if (m_armed) begin
      m_idx++;
    end
  endtask

  task automatic cs_low();
    m_armed       = 1'b0;
    m_idx         = 0;
    d_armed       = 1'b0;
    d_addr        = 3'd0;
    reg_rd_addr_i = 3'd0;
    spi_cs_n_i    = 1'b0;
  endtask

  task automatic cs_high();
    tick(H);
    spi_cs_n_i = 1'b1;
    tick(4);
    chk("oe_after_cs", {31'h0, spi_miso_oe_o}, 32'h0);
    tick(H);
  endtask

  initial begin
    logic [7:0] got, b;
    int c0, n, r;
    rst_n_i         = 1'b0;
    spi_sclk_i      = 1'b0;
    spi_cs_n_i      = 1'b1;
    dc_i            = 1'b0;
    spi_byte_vld_i  = 1'b0;
    spi_byte_data_i = 8'h00;
    reg_rd_addr_i   = 3'd0;
    regs[0] = 8'hA5;
    regs[1] = 8'h3C;
    for (int k = 2; k < RB; k++) regs[k] = 8'($urandom);
    apply_regs();
    m_armed = 1'b0;
    m_idx   = 0;
    d_armed = 1'b0;
    d_addr  = 3'd0;
    tick(3);
    rst_n_i = 1'b1;
    tick(2);
    chk("rst_miso", {31'h0, spi_miso_o}, 32'h0);
    chk("rst_oe", {31'h0, spi_miso_oe_o}, 32'h0);
    chk("rst_done", {31'h0, tx_byte_done_o}, 32'h0);

    c0 = done_cnt;
    repeat ($urandom_range(3, 8)) begin
      spi_sclk_i = ~spi_sclk_i;
      tick($urandom_range(2, 10));
      chk("idle_miso", {31'h0, spi_miso_o}, 32'h0);
      chk("idle_oe", {31'h0, spi_miso_oe_o}, 32'h0);
    end
    spi_sclk_i = 1'b0;
    tick(H);
    chk("idle_done", 32'(done_cnt - c0), 32'h0);

    cs_low();
    send(8'h3a, 1'b0);
    send(8'hFF, 1'b1);
    send(8'hFF, 1'b1);
    cs_high();

    cs_low();
    send(8'h2a, 1'b0);
    send(8'($urandom), 1'b1);
    cs_high();

    cs_low();
    send(8'h3a, 1'b0);
    c0 = done_cnt;
    shift_bits(8'($urandom), 1'b1, 3, got);
    spi_cs_n_i = 1'b1;
    tick(4);
    chk("abort_oe", {31'h0, spi_miso_oe_o}, 32'h0);
    tick(H);
    chk("abort_done", 32'(done_cnt - c0), 32'h0);
    cs_low();
    send(8'h00, 1'b0);
    send(8'($urandom), 1'b1);
    cs_high();

    for (int k = 0; k < RB; k++) regs[k] = 8'($urandom);
    apply_regs();
    cs_low();
    send(8'h3a, 1'b0);
    for (int j = 0; j < 6; j++) send(8'($urandom), 1'b1);
    cs_high();

    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < RB; k++) regs[k] = 8'($urandom);
      apply_regs();
      cs_low();
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        r = $urandom_range(0, 3);
        b = 8'($urandom);
        if (j == 0 || r == 0) send(8'h3a, 1'b0);
        else if (r == 1) send(b, 1'b0);
        else send(b, 1'b1);
      end
      cs_high();
    end

    regs[0] = 8'hE0 | 8'($urandom_range(0, 31));
    apply_regs();
    cs_low();
    send(8'h3a, 1'b0);
    shift_bits(8'($urandom), 1'b1, 2, got);
    tick(H);
    chk("pre_rst_miso", {31'h0, spi_miso_o}, 32'h1);
    chk("pre_rst_oe", {31'h0, spi_miso_oe_o}, 32'h1);
    spi_sclk_i = 1'b1;
    tick(2);
    rst_n_i = 1'b0;
    #1;
    chk("async_rst_miso", {31'h0, spi_miso_o}, 32'h0);
    chk("async_rst_oe", {31'h0, spi_miso_oe_o}, 32'h0);
    chk("async_rst_done", {31'h0, tx_byte_done_o}, 32'h0);
    spi_sclk_i = 1'b0;
    spi_cs_n_i = 1'b1;
    tick(3);
    rst_n_i = 1'b1;
    tick(H);
    cs_low();
    send(8'($urandom), 1'b1);
    cs_high();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
